// File: rtl/punc_mem_arbiter.sv
// Single-port memory sequencer for PUnC: arbitrates fetch, data and debug ports,
// issues one access at a time and returns registered read data to the winner.
module punc_mem_arbiter #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int RD_LAT = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [2:0]            req,
  input  logic [2:0]            we,
  input  logic [3*ADDR_W-1:0]   addr,
  input  logic [3*DATA_W-1:0]   wdata,
  output logic [2:0]            gnt,
  output logic [2:0]            rvalid,
  output logic [DATA_W-1:0]     rdata,
  output logic                  busy,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic [DATA_W-1:0]     mem_rdata
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  localparam logic [2:0] LAT = 3'(RD_LAT);

  state_t              state, state_nxt;
  logic [2:0]          sel, sel_nxt;
  logic                last, last_nxt;
  logic [2:0]          cnt, cnt_nxt;
  logic [2:0]          win;
  logic [2:0]          gnt_nxt, rvalid_nxt;
  logic [DATA_W-1:0]   rdata_nxt;
  logic                busy_nxt, mem_en_nxt, mem_we_nxt;
  logic [ADDR_W-1:0]   mem_addr_nxt;
  logic [DATA_W-1:0]   mem_wdata_nxt;

  // Debug always wins; on a fetch/data tie, the port not granted last goes.
  function automatic logic [2:0] pick(input logic [2:0] r, input logic lst);
    if (r[2])         return 3'b100;
    if (r[0] && r[1]) return lst ? 3'b001 : 3'b010;
    if (r[0])         return 3'b001;
    if (r[1])         return 3'b010;
    return 3'b000;
  endfunction

  assign win = pick(req, last);

  always_comb begin
    state_nxt     = state;
    sel_nxt       = sel;
    last_nxt      = last;
    cnt_nxt       = cnt;
    gnt_nxt       = 3'b000;
    rvalid_nxt    = 3'b000;
    rdata_nxt     = rdata;
    mem_en_nxt    = 1'b0;
    mem_we_nxt    = 1'b0;
    mem_addr_nxt  = mem_addr;
    mem_wdata_nxt = mem_wdata;
    case (state)
      IDLE: begin
        if (|req) begin
          state_nxt  = ISSUE;
          sel_nxt    = win;
          gnt_nxt    = win;
          mem_en_nxt = 1'b1;
          mem_we_nxt = |(we & win);
          for (int i = 0; i < 3; i++) begin
            if (win[i]) begin
              mem_addr_nxt  = addr[i*ADDR_W +: ADDR_W];
              mem_wdata_nxt = wdata[i*DATA_W +: DATA_W];
            end
          end
          if (!win[2]) last_nxt = win[1];
        end
      end
      // mem_we still holds the latched write flag during ISSUE
      ISSUE: begin
        if (mem_we) begin
          state_nxt = IDLE;
        end else begin
          state_nxt = WAIT;
          cnt_nxt   = LAT;
        end
      end
      WAIT: begin
        cnt_nxt = cnt - 3'd1;
        if (cnt == 3'd1) begin
          rdata_nxt  = mem_rdata;
          rvalid_nxt = sel;
          state_nxt  = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    busy_nxt = (state_nxt != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      sel       <= 3'b000;
      last      <= 1'b1;
      cnt       <= 3'd0;
      gnt       <= 3'b000;
      rvalid    <= 3'b000;
      rdata     <= '0;
      busy      <= 1'b0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      state     <= state_nxt;
      sel       <= sel_nxt;
      last      <= last_nxt;
      cnt       <= cnt_nxt;
      gnt       <= gnt_nxt;
      rvalid    <= rvalid_nxt;
      rdata     <= rdata_nxt;
      busy      <= busy_nxt;
      mem_en    <= mem_en_nxt;
      mem_we    <= mem_we_nxt;
      mem_addr  <= mem_addr_nxt;
      mem_wdata <= mem_wdata_nxt;
    end
  end

endmodule

// File: tb/tb_punc_mem_arbiter.sv
// Scoreboard bench for punc_mem_arbiter: a transaction-level arbitration model
// predicts grants and read returns; a monitor compares them against the DUT.
module tb_punc_mem_arbiter;

  localparam int RD_LAT = 3;

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
  } txn_t;

  typedef struct {
    int          cyc;
    logic [2:0]  port;
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
  } gexp_t;

  typedef struct {
    int          cyc;
    logic [2:0]  port;
    logic [15:0] data;
  } rexp_t;

  logic        clk, rst;
  logic [2:0]  req, we;
  logic [47:0] addr, wdata;
  logic [2:0]  gnt, rvalid;
  logic [15:0] rdata, mem_addr, mem_wdata, mem_rdata;
  logic        busy, mem_en, mem_we;

  punc_mem_arbiter #(.ADDR_W(16), .DATA_W(16), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .busy(busy),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  txn_t  pq[3][$];
  logic [2:0] active;
  gexp_t gq[$];
  rexp_t rq[$];

  // reference model state
  int          m_free, b_lo, b_hi;
  logic        m_last;
  logic [15:0] h_addr, h_wdata, h_rdata;

  logic [15:0] mem_arr [logic [15:0]];
  logic [15:0] ref_arr [logic [15:0]];
  logic [15:0] pipe [RD_LAT];

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [15:0] mem_rd(input logic [15:0] a);
    return mem_arr.exists(a) ? mem_arr[a] : (a ^ 16'h5A5A);
  endfunction

  function automatic logic [15:0] ref_rd(input logic [15:0] a);
    return ref_arr.exists(a) ? ref_arr[a] : (a ^ 16'h5A5A);
  endfunction

  // memory macro: writes on mem_en&mem_we, reads appear RD_LAT cycles later
  always @(posedge clk) begin
    if (mem_en && mem_we) mem_arr[mem_addr] = mem_wdata;
    for (int k = RD_LAT - 1; k > 0; k--) pipe[k] <= pipe[k-1];
    pipe[0] <= (mem_en && !mem_we) ? mem_rd(mem_addr) : 16'($urandom);
  end
  assign mem_rdata = pipe[RD_LAT-1];

  // requesters: present queue head until granted, randomize idle address lines
  initial begin
    req = 3'b000; we = 3'b000; addr = '0; wdata = '0; active = 3'b000;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        req = 3'b000;
        active = 3'b000;
      end else begin
        for (int i = 0; i < 3; i++) begin
          if (active[i] && gnt[i]) begin
            void'(pq[i].pop_front());
            active[i] = 1'b0;
          end
        end
        for (int i = 0; i < 3; i++) begin
          if (pq[i].size() > 0) begin
            req[i] = 1'b1;
            we[i]  = pq[i][0].we;
            addr[i*16 +: 16]  = pq[i][0].addr;
            wdata[i*16 +: 16] = pq[i][0].wdata;
            active[i] = 1'b1;
          end else begin
            req[i] = 1'b0;
            addr[i*16 +: 16]  = 16'($urandom);
            wdata[i*16 +: 16] = 16'($urandom);
            we[i] = 1'($urandom);
          end
        end
      end
    end
  end

  // monitor + reference model
  always @(negedge clk) begin
    gexp_t g;
    rexp_t r;
    int w;
    if (rst) begin
      m_free = 0; b_lo = 0; b_hi = 0; m_last = 1'b1;
      h_addr = 16'h0; h_wdata = 16'h0; h_rdata = 16'h0;
      gq.delete(); rq.delete();
    end else begin
      if (gnt != 3'b000) begin
        if (gq.size() == 0) chk("gnt_unexpected", 32'(gnt), 32'h0);
        else begin
          g = gq.pop_front();
          chk("gnt_port", 32'(gnt), 32'(g.port));
          chk("gnt_cycle", 32'(cyc), 32'(g.cyc));
          chk("mem_en", 32'(mem_en), 32'h1);
          chk("mem_we", 32'(mem_we), 32'(g.we));
          chk("mem_addr", 32'(mem_addr), 32'(g.addr));
          chk("mem_wdata", 32'(mem_wdata), 32'(g.wdata));
          h_addr = g.addr; h_wdata = g.wdata;
        end
      end else begin
        if (gq.size() > 0 && gq[0].cyc <= cyc) begin
          chk("gnt_missing", 32'(gnt), 32'(gq[0].port));
          void'(gq.pop_front());
        end
        chk("idle_strobes", 32'({mem_en, mem_we}), 32'h0);
        chk("hold_addr", 32'(mem_addr), 32'(h_addr));
        chk("hold_wdata", 32'(mem_wdata), 32'(h_wdata));
      end
      if (rvalid != 3'b000) begin
        if (rq.size() == 0) chk("rvalid_unexpected", 32'(rvalid), 32'h0);
        else begin
          r = rq.pop_front();
          chk("rvalid_port", 32'(rvalid), 32'(r.port));
          chk("rvalid_cycle", 32'(cyc), 32'(r.cyc));
          chk("rdata", 32'(rdata), 32'(r.data));
          h_rdata = r.data;
        end
      end else begin
        if (rq.size() > 0 && rq[0].cyc <= cyc) begin
          chk("rvalid_missing", 32'(rvalid), 32'(rq[0].port));
          void'(rq.pop_front());
        end
        chk("rdata_hold", 32'(rdata), 32'(h_rdata));
      end
      chk("busy", 32'(busy), 32'(cyc >= b_lo && cyc < b_hi));
      // arbitration decision for the request seen in this idle cycle
      if (cyc >= m_free && req != 3'b000) begin
        if (req[2]) w = 2;
        else if (req[0] && req[1]) w = m_last ? 0 : 1;
        else if (req[0]) w = 0;
        else w = 1;
        if (w != 2) m_last = (w == 1);
        g.cyc = cyc + 1; g.port = 3'b001 << w; g.we = we[w];
        g.addr = addr[w*16 +: 16]; g.wdata = wdata[w*16 +: 16];
        gq.push_back(g);
        if (g.we) begin
          ref_arr[g.addr] = g.wdata;
          m_free = cyc + 2;
        end else begin
          r.cyc = cyc + 2 + RD_LAT; r.port = g.port; r.data = ref_rd(g.addr);
          rq.push_back(r);
          m_free = cyc + 2 + RD_LAT;
        end
        b_lo = cyc + 1; b_hi = m_free;
      end
    end
  end

  task automatic push(input int p, input logic w, input logic [15:0] a, input logic [15:0] d);
    txn_t t;
    t.we = w; t.addr = a; t.wdata = d;
    pq[p].push_back(t);
  endtask

  task automatic drain();
    bit done = 0;
    for (int k = 0; k < 400 && !done; k++) begin
      @(negedge clk);
      done = (pq[0].size() == 0 && pq[1].size() == 0 && pq[2].size() == 0 &&
              gq.size() == 0 && rq.size() == 0 && cyc >= m_free);
    end
    if (!done) begin
      n_checks++; n_fail++;
      $display("FAIL drain_timeout: traffic still pending at cycle %0d", cyc);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_gnt"}, 32'(gnt), 32'h0);
    chk({tag, "_rvalid"}, 32'(rvalid), 32'h0);
    chk({tag, "_rdata"}, 32'(rdata), 32'h0);
    chk({tag, "_strobes"}, 32'({mem_en, mem_we, busy}), 32'h0);
    chk({tag, "_mem_addr"}, 32'(mem_addr), 32'h0);
    chk({tag, "_mem_wdata"}, 32'(mem_wdata), 32'h0);
  endtask

  initial begin
    bit seen;
    rst = 1'b1;
    mem_arr[16'h3000] = 16'h1234; ref_arr[16'h3000] = 16'h1234;
    mem_arr[16'h0010] = 16'hA5A5; ref_arr[16'h0010] = 16'hA5A5;
    repeat (2) @(posedge clk);
    #2 chk_zero("reset");
    @(negedge clk); #1 rst = 1'b0;

    // single fetch read, then data write and read-back
    push(0, 1'b0, 16'h3000, 16'h0000);
    drain();
    push(1, 1'b1, 16'h4000, 16'hBEEF);
    drain();
    push(1, 1'b0, 16'h4000, 16'h0000);
    drain();

    // fetch and data both streaming reads
    for (int i = 0; i < 4; i++) begin
      push(0, 1'b0, 16'h3000 + 16'(i), 16'h0);
      push(1, 1'b0, 16'h0200 + 16'(i), 16'h0);
    end
    drain();

    // all three ports at once
    for (int i = 0; i < 2; i++) begin
      push(2, 1'b0, 16'h0400 + 16'(i), 16'h0);
      push(0, 1'b0, 16'h0500 + 16'(i), 16'h0);
      push(1, 1'b1, 16'h0600 + 16'(i), 16'h1111 * 16'(i + 1));
    end
    drain();

    // long-latency data read while idle fetch lines wiggle
    push(1, 1'b0, 16'h0010, 16'h0);
    drain();

    // reset during WAIT abandons the read
    push(1, 1'b0, 16'h0020, 16'h0);
    seen = 0;
    for (int k = 0; k < 30 && !seen; k++) begin
      @(negedge clk);
      seen = gnt[1];
    end
    if (!seen) begin
      n_checks++; n_fail++;
      $display("FAIL mid_wait_gnt: no grant for port 1 by cycle %0d", cyc);
    end
    @(posedge clk);
    #2 rst = 1'b1;
    pq[0].delete(); pq[1].delete(); pq[2].delete();
    #1 chk_zero("async_reset");
    @(negedge clk); #1 rst = 1'b0;
    repeat (RD_LAT + 3) @(negedge clk);
    push(0, 1'b0, 16'h0700, 16'h0);
    push(1, 1'b0, 16'h0701, 16'h0);
    drain();

    // randomized mixed traffic over a small address pool
    for (int i = 0; i < 150; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 2) == 0)
        push($urandom_range(0, 2), 1'($urandom), 16'h0100 + 16'($urandom_range(0, 7)),
             16'($urandom));
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
